// File: rtl/multi_byte_add_sequencer.sv
// Byte-serial add/subtract of two NBYTES*8-bit operands through one shared 8-bit adder.
// LSB byte first, carry registered between bytes, result presented with a one-cycle done pulse.

module eight_bit_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
endmodule

// state | meaning
// IDLE  | waiting for start; done may be high for the one cycle after completion
// RUN   | one operand byte per clock, idx selects the byte, carry held in carry_q
module multi_byte_add_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic                cin,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout
);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state;
    logic [NBYTES-1:0][7:0]   opa;
    logic [NBYTES-1:0][7:0]   opb;
    logic [NBYTES-1:0][7:0]   acc;
    logic [NBYTES-1:0][7:0]   acc_next;
    logic [IW-1:0]            idx;
    logic                     carry_q;
    logic [7:0]               add_sum;
    logic                     add_cout;

    eight_bit_adder u_adder (
        .a    (opa[idx]),
        .b    (opb[idx]),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Accumulator with the current byte merged in, so the final byte reaches sum on the same edge.
    always_comb begin
        acc_next      = acc;
        acc_next[idx] = add_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            idx     <= '0;
            carry_q <= 1'b0;
            opa     <= '0;
            opb     <= '0;
            acc     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa     <= a;
                        opb     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc     <= acc_next;
                    carry_q <= add_cout;
                    if (idx == LAST) begin
                        sum   <= acc_next;
                        cout  <= add_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        idx   <= '0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_byte_add_sequencer.sv
// Scoreboard bench: accepted requests push an arithmetic reference result; a monitor pops on done.
// A cycle-level reference tracks busy/done timing and the held sum/cout.

module tb_multi_byte_add_sequencer;
    localparam int NBYTES = 4;
    localparam int W = 8 * NBYTES;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    res_t         exp_q[$];
    int           n_chk = 0;
    int           n_fail = 0;
    int           n_done = 0;
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    bit           checking = 1'b0;

    multi_byte_add_sequencer #(.NBYTES(NBYTES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    function automatic res_t ref_op(logic [W-1:0] x, logic [W-1:0] y, logic s, logic c);
        res_t r;
        logic [W:0] t;
        if (s) begin
            r.s = x - y;
            r.c = (x >= y);
        end else begin
            t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
            r.s = t[W-1:0];
            r.c = t[W];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference timing: accept when idle, done one cycle after NBYTES run edges.
    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_sum  = '0;
            m_cout = 1'b0;
            exp_q.delete();
        end else if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
        end else begin
            m_done = 1'b0;
            if (start) begin
                exp_q.push_back(ref_op(a, b, sub, cin));
                m_left = NBYTES;
            end
        end
    end

    always @(negedge clk) begin
        res_t r;
        if (checking) begin
            chk("busy", busy, m_left > 0);
            chk("done", done, m_done);
            if (done === 1'b1) begin
                n_done++;
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_without_request at %0t: got done=1 expected no pending request", $time);
                end else begin
                    r = exp_q.pop_front();
                    m_sum  = r.s;
                    m_cout = r.c;
                end
            end
            chk("sum", sum, m_sum);
            chk("cout", cout, m_cout);
        end
    end

    function automatic logic [W-1:0] pick();
        case ($urandom % 5)
            0: return '1;
            1: return '0;
            2: return W'(1);
            default: return W'($urandom);
        endcase
    endfunction

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input logic c);
        start = 1'b1;
        a = x;
        b = y;
        sub = s;
        cin = c;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < NBYTES; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            sub = 1'($urandom);
            cin = 1'($urandom);
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checking = 1'b1;
        @(negedge clk);

        op('0, '0, 1'b0, 1'b0);
        op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        op(32'd7, 32'd5, 1'b1, 1'b0);
        op(32'd5, 32'd7, 1'b1, 1'b0);

        // start held high: second request accepted in the done cycle
        start = 1'b1;
        a = 32'd1;
        b = 32'd1;
        sub = 1'b0;
        cin = 1'b0;
        repeat (2) @(negedge clk);
        a = 32'd2;
        b = 32'd2;
        repeat (5) @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);

        // reset during the second RUN cycle aborts the operation
        op(32'd3, 32'd4, 1'b0, 1'b0);
        start = 1'b1;
        a = 32'h10;
        b = 32'h20;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 400; i++) begin
            start = ($urandom % 3 == 0);
            a = pick();
            b = pick();
            sub = 1'($urandom);
            cin = 1'($urandom);
            rst = ($urandom % 150 == 0);
            @(negedge clk);
        end
        start = 1'b0;
        rst = 1'b0;
        repeat (NBYTES + 3) @(negedge clk);

        chk("queue_drained", exp_q.size(), 0);
        chk("done_pulses_seen", n_done >= 20, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
